hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Works alongside the forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use
  - multi-cycle HI/LO (mult/div) occupancy
  - data-memory wait handshake with timeout
  - taken-branch fetch flush
- Drives per-stage stall and flush controls to the F/D, D/E, E/M and M/WB pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl_mdu_busy_ctr.sv | 28 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: FSM encoding,
// register constants and a small saturating-increment helper.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         WAIT_CNT_W = 8;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
        return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, per-stage stall/flush out.
// The slave side is the controller; the master side is the pipeline.
interface hazard_ctrl_if;
    logic [4:0] instrRs_D;
    logic [4:0] instrRt_D;
    logic       usesRt_D;
    logic       readsHiLo_D;
    logic       branchTaken_D;
    logic [4:0] writeReg_E;
    logic       regWrite_E;
    logic       memToReg_E;
    logic       mduStart_E;
    logic       memReq_M;
    logic       memReady_M;
    logic       stall_F;
    logic       stall_D;
    logic       stall_E;
    logic       stall_M;
    logic       flush_D;
    logic       flush_E;
    logic       flush_M;
    logic       flush_WB;
    logic       mduBusy;
    logic       memTimeout;

    modport master (
        output instrRs_D, instrRt_D, usesRt_D, readsHiLo_D, branchTaken_D,
               writeReg_E, regWrite_E, memToReg_E, mduStart_E,
               memReq_M, memReady_M,
        input  stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_WB, mduBusy, memTimeout
    );

    modport slave (
        input  instrRs_D, instrRt_D, usesRt_D, readsHiLo_D, branchTaken_D,
               writeReg_E, regWrite_E, memToReg_E, mduStart_E,
               memReq_M, memReady_M,
        output stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_WB, mduBusy, memTimeout
    );
endinterface

// File: rtl/hazard_ctrl_mdu_busy_ctr.sv
// Loadable 4-bit down-counter tracking mult/div occupancy; busy while nonzero.
module mdu_busy_ctr #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = 4'(LATENCY);
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != 4'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for hazards the forwarding network cannot cover:
// load-use, HI/LO occupancy, data-memory wait/timeout and taken branches.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | no memory access outstanding beyond the current cycle
// ST_MEM_WAIT | data memory access pending, counting wait cycles
// ST_MEM_ERR  | memory timed out; pipeline frozen until reset
module hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst_n,
    hazard_ctrl_if.slave  hz
);
    hz_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mdu_busy, mdu_load;
    logic mem_err, mem_stall, mdu_struct, load_use, hilo;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_wb;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (hz.memReq_M && !hz.memReady_M)
                    state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                wait_cnt_d = sat_inc(wait_cnt_q);
                if (hz.memReady_M)
                    state_d = ST_RUN;
                else if (wait_cnt_d == WAIT_CNT_W'(MEM_TIMEOUT))
                    state_d = ST_MEM_ERR;
            end
            ST_MEM_ERR: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem_err   = (state_q == ST_MEM_ERR);
    assign mem_stall = ((state_q == ST_RUN) && hz.memReq_M && !hz.memReady_M) ||
                       ((state_q == ST_MEM_WAIT) && !hz.memReady_M);
    assign mdu_struct = hz.mduStart_E && mdu_busy;
    assign hilo       = hz.readsHiLo_D && mdu_busy;
    assign load_use   = hz.regWrite_E && hz.memToReg_E && (hz.writeReg_E != REG_ZERO) &&
                        ((hz.writeReg_E == hz.instrRs_D) ||
                         (hz.usesRt_D && (hz.writeReg_E == hz.instrRt_D)));

    // Priority chain; every branch above the branch flush holds decode, so
    // flush_D only ever fires for an unstalled decode.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        flush_wb = 1'b0;
        if (mem_err || mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            flush_wb = 1'b1;
        end else if (mdu_struct) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (load_use || hilo) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (hz.branchTaken_D) begin
            flush_d = 1'b1;
        end
    end

    assign mdu_load = hz.mduStart_E && !stall_e && !mdu_busy;

    mdu_busy_ctr #(
        .LATENCY (MDU_LATENCY)
    ) u_mdu_busy_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (mdu_load),
        .busy_o (mdu_busy)
    );

    // Gated by rst_n so the pipeline sees no stall or bubble while in reset,
    // even if upstream stages still present a hazard.
    assign hz.stall_F    = rst_n && stall_f;
    assign hz.stall_D    = rst_n && stall_d;
    assign hz.stall_E    = rst_n && stall_e;
    assign hz.stall_M    = rst_n && stall_m;
    assign hz.flush_D    = rst_n && flush_d;
    assign hz.flush_E    = rst_n && flush_e;
    assign hz.flush_M    = rst_n && flush_m;
    assign hz.flush_WB   = rst_n && flush_wb;
    assign hz.mduBusy    = mdu_busy;
    assign hz.memTimeout = mem_err;
endmodule
